// File: rtl/phy_rx_deser_if.sv
// phy_rx_deser_if: bundles the serial input and parallel lane outputs of the
// receive deserialiser.
//
// Ports (signals):
//   data_in    serial bit, MSB first, into the deserialiser
//   active     link locked and receiving
//   valid      one-cycle strobe per decoded data byte
//   data_out   LANES*WIDTH lane word, lane k at [k*WIDTH +: WIDTH]
//   valid_out  per-lane valid mask for data_out
//   out_stb    one-cycle strobe when data_out/valid_out update
//   state_dbg  current alignment FSM state (SEARCH=0, ALIGN=1, ACTIVE=2)
//
// Handshake: valid and out_stb are single-cycle strobes with no backpressure;
// the consumer must sample data_out/valid_out in the cycle out_stb is high
// (both are also held stable until the next strobe).
interface phy_rx_deser_if #(
    parameter int WIDTH = 8,
    parameter int LANES = 4
);
    logic                   data_in;
    logic                   active;
    logic                   valid;
    logic [LANES*WIDTH-1:0] data_out;
    logic [LANES-1:0]       valid_out;
    logic                   out_stb;
    logic [1:0]             state_dbg;

    // master: the deserialiser itself; slave: the lane consumer / source of bits
    modport master (
        input  data_in,
        output active, valid, data_out, valid_out, out_stb, state_dbg
    );
    modport slave (
        output data_in,
        input  active, valid, data_out, valid_out, out_stb, state_dbg
    );
endinterface

// File: rtl/phy_rx_deser.sv
// phy_rx_deser: serial receive path. Bit-slips on the COM symbol to find byte
// alignment, declares the link active after SYNC_COUNT consecutive aligned
// COMs, then distributes data bytes round-robin across LANES lanes. A full
// group is emitted as one lane word; a partial group is flushed by COM/IDL.
//
// Ports:
//   clk             bit-rate clock, rising edge
//   default_values  asynchronous active-low reset
//   bus             phy_rx_deser_if.master (data_in in; active, valid,
//                   data_out, valid_out, out_stb, state_dbg out)
module phy_rx_deser #(
    parameter int               WIDTH      = 8,
    parameter int               LANES      = 4,
    parameter logic [WIDTH-1:0] COM        = 8'hBC,
    parameter logic [WIDTH-1:0] IDL        = 8'h7C,
    parameter int               SYNC_COUNT = 4
) (
    input  logic              clk,
    input  logic              default_values,
    phy_rx_deser_if.master    bus
);
    localparam int PTR_W = $clog2(LANES);
    localparam int CNT_W = $clog2(SYNC_COUNT + 1);
    localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(LANES - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_SYNC = CNT_W'(SYNC_COUNT);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t                 state, state_next;
    logic [WIDTH-2:0]       sr;
    logic [WIDTH-1:0]       incoming;
    logic [BIT_W-1:0]       bit_cnt, bit_cnt_next;
    logic [CNT_W-1:0]       com_cnt, com_cnt_next, com_inc;
    logic [PTR_W-1:0]       ptr;
    logic [LANES*WIDTH-1:0] lane_buf, buf_new, flush_word;
    logic [LANES-1:0]       fill_mask;
    logic                   is_com, is_ctrl, boundary, data_evt, ctrl_evt;

    logic                   active_q, valid_q, out_stb_q;
    logic [LANES*WIDTH-1:0] data_out_q;
    logic [LANES-1:0]       valid_out_q;

    // The byte completing at this edge includes the bit being sampled now.
    assign incoming = {sr, bus.data_in};
    assign is_com   = (incoming == COM);
    assign is_ctrl  = is_com || (incoming == IDL);
    assign boundary = (bit_cnt == BIT_LAST);
    assign com_inc  = (com_cnt == CNT_SYNC) ? com_cnt : com_cnt + 1'b1;

    always_ff @(posedge clk or negedge default_values) begin
        if (!default_values) begin
            state   <= SEARCH;
            bit_cnt <= '0;
            com_cnt <= '0;
        end else begin
            state   <= state_next;
            bit_cnt <= bit_cnt_next;
            com_cnt <= com_cnt_next;
        end
    end

    always_comb begin
        state_next   = state;
        bit_cnt_next = bit_cnt;
        com_cnt_next = com_cnt;
        data_evt     = 1'b0;
        ctrl_evt     = 1'b0;
        case (state)
            SEARCH: begin
                // Bit-slip: every cycle is a candidate byte boundary.
                bit_cnt_next = '0;
                if (is_com) begin
                    com_cnt_next = CNT_W'(1);
                    state_next   = (SYNC_COUNT == 1) ? ACTIVE : ALIGN;
                end
            end
            ALIGN: begin
                bit_cnt_next = boundary ? '0 : bit_cnt + 1'b1;
                if (boundary) begin
                    if (is_com) begin
                        com_cnt_next = com_inc;
                        if (com_inc == CNT_SYNC) state_next = ACTIVE;
                    end else begin
                        com_cnt_next = '0;
                        state_next   = SEARCH;
                    end
                end
            end
            ACTIVE: begin
                // No loss-of-lock detection: stays here until reset.
                bit_cnt_next = boundary ? '0 : bit_cnt + 1'b1;
                if (boundary) begin
                    ctrl_evt = is_ctrl;
                    data_evt = !is_ctrl;
                end
            end
            default: state_next = SEARCH;
        endcase
    end

    // Buffer with the incoming byte placed at the current lane, and the
    // flush view that zeroes lanes not yet written in this group (they may
    // still hold bytes from an earlier group).
    always_comb begin
        buf_new    = lane_buf;
        flush_word = '0;
        fill_mask  = '0;
        for (int k = 0; k < LANES; k++) begin
            if (k == int'(ptr)) buf_new[k*WIDTH +: WIDTH] = incoming;
            if (k < int'(ptr)) begin
                flush_word[k*WIDTH +: WIDTH] = lane_buf[k*WIDTH +: WIDTH];
                fill_mask[k]                 = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge default_values) begin
        if (!default_values) begin
            sr          <= '0;
            ptr         <= '0;
            lane_buf    <= '0;
            active_q    <= 1'b0;
            valid_q     <= 1'b0;
            out_stb_q   <= 1'b0;
            data_out_q  <= '0;
            valid_out_q <= '0;
        end else begin
            sr        <= incoming[WIDTH-2:0];
            active_q  <= (state_next == ACTIVE);
            valid_q   <= data_evt;
            out_stb_q <= 1'b0;
            if (data_evt) begin
                lane_buf <= buf_new;
                if (ptr == PTR_LAST) begin
                    data_out_q  <= buf_new;
                    valid_out_q <= '1;
                    out_stb_q   <= 1'b1;
                    ptr         <= '0;
                end else begin
                    ptr <= ptr + 1'b1;
                end
            end
            if (ctrl_evt && (ptr != '0)) begin
                data_out_q  <= flush_word;
                valid_out_q <= fill_mask;
                out_stb_q   <= 1'b1;
                ptr         <= '0;
            end
        end
    end

    assign bus.active    = active_q;
    assign bus.valid     = valid_q;
    assign bus.out_stb   = out_stb_q;
    assign bus.data_out  = data_out_q;
    assign bus.valid_out = valid_out_q;
    assign bus.state_dbg = state;
endmodule

// File: tb/tb_phy_rx_deser.sv
module tb_phy_rx_deser;
    localparam int WIDTH = 8;
    localparam int LANES = 4;
    localparam int OW    = LANES + LANES * WIDTH;
    localparam logic [7:0] COM = 8'hBC;
    localparam logic [7:0] IDL = 8'h7C;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic default_values;
    always #5 clk = ~clk;

    phy_rx_deser_if #(.WIDTH(WIDTH), .LANES(LANES)) bus ();

    phy_rx_deser #(
        .WIDTH(WIDTH), .LANES(LANES), .COM(COM), .IDL(IDL), .SYNC_COUNT(4)
    ) dut (
        .clk(clk),
        .default_values(default_values),
        .bus(bus)
    );

    // ---------------- scoreboard state ----------------
    int pass_cnt  = 0;
    int total_cnt = 0;
    int valid_cnt = 0;
    logic [OW-1:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (default_values === 1'b1) begin
            if (bus.valid === 1'b1) valid_cnt++;
            if (bus.out_stb === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL unexpected_out_stb: got %0h expected no strobe",
                             {bus.valid_out, bus.data_out});
                end else begin
                    logic [OW-1:0] e;
                    e = exp_q.pop_front();
                    chk("lane_word", 64'({bus.valid_out, bus.data_out}), 64'(e));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_bit(input logic b);
        @(negedge clk);
        bus.data_in = b;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = WIDTH - 1; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_active"},    64'(bus.active),    64'd0);
        chk({tag, "_valid"},     64'(bus.valid),     64'd0);
        chk({tag, "_out_stb"},   64'(bus.out_stb),   64'd0);
        chk({tag, "_data_out"},  64'(bus.data_out),  64'd0);
        chk({tag, "_valid_out"}, 64'(bus.valid_out), 64'd0);
        chk({tag, "_state"},     64'(bus.state_dbg), 64'd0);
    endtask

    task automatic do_reset();
        default_values = 1'b0;
        bus.data_in    = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk_zero_outputs("reset");
        @(negedge clk);
        default_values = 1'b1;
    endtask

    // Four aligned COMs; active must still be low before the last bit's edge
    // and high right after it.
    task automatic lock_seq(input string tag);
        repeat (4) send_byte(COM);
        chk({tag, "_active_pre"}, 64'(bus.active), 64'd0);
        @(posedge clk);
        #1;
        chk({tag, "_active_post"}, 64'(bus.active), 64'd1);
        chk({tag, "_state_active"}, 64'(bus.state_dbg), 64'd2);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int v0;
        default_values = 1'b0;
        bus.data_in    = 1'b0;

        // Lock, no data strobes while locking
        do_reset();
        lock_seq("lock");
        send_byte(IDL);
        send_byte(IDL);
        #2;
        chk("lock_no_valid", 64'(valid_cnt), 64'd0);

        // False lock: three COMs then a non-COM byte
        do_reset();
        repeat (3) send_byte(COM);
        chk("false_align_state", 64'(bus.state_dbg), 64'd1);
        send_byte(8'h00);
        @(posedge clk);
        #1;
        chk("false_state_search", 64'(bus.state_dbg), 64'd0);
        chk("false_active", 64'(bus.active), 64'd0);
        lock_seq("relock");

        // Full group
        v0 = valid_cnt;
        exp_q.push_back({4'b1111, 32'h44332211});
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        send_byte(IDL);
        #2;
        chk("full_valid_pulses", 64'(valid_cnt - v0), 64'd4);
        chk("full_hold_data", 64'(bus.data_out), 64'h44332211);
        chk("full_hold_mask", 64'(bus.valid_out), 64'hf);

        // Partial flush on IDL; lanes 2/3 still hold 33/44 and must be zeroed
        v0 = valid_cnt;
        exp_q.push_back({4'b0011, 32'h00006655});
        send_byte(8'h55); send_byte(8'h66); send_byte(IDL);
        send_byte(IDL);
        #2;
        chk("partial_valid_pulses", 64'(valid_cnt - v0), 64'd2);
        chk("partial_hold_data", 64'(bus.data_out), 64'h00006655);
        chk("partial_hold_mask", 64'(bus.valid_out), 64'h3);

        // Single-lane flush on COM
        exp_q.push_back({4'b0001, 32'h00000077});
        send_byte(8'h77); send_byte(COM); send_byte(IDL);

        // Bit slip: three junk bits before the COMs
        do_reset();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        lock_seq("slip");
        v0 = valid_cnt;
        exp_q.push_back({4'b0001, 32'h00000011});
        send_byte(8'h11); send_byte(IDL); send_byte(IDL);
        #2;
        chk("slip_valid_pulses", 64'(valid_cnt - v0), 64'd1);

        // Reset mid-group: partial group must be discarded
        do_reset();
        lock_seq("mid");
        send_byte(8'h11); send_byte(8'h22);
        default_values = 1'b0;
        #1;
        chk_zero_outputs("midrst");
        bus.data_in = 1'b0;
        repeat (3) @(negedge clk);
        default_values = 1'b1;
        send_byte(8'h00); send_byte(8'h00);
        #2;
        chk("midrst_active_low", 64'(bus.active), 64'd0);
        lock_seq("midrst_relock");
        send_byte(IDL); send_byte(IDL);

        repeat (4) @(negedge clk);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/phy_rx_deser.md
Name: phy_rx_deser

Overview:
- Parametrised single-clock successor to the physical-layer receive path.
- Accepts a serial bit stream (MSB first) and bit-slips to find byte alignment on the COM symbol.
- Declares link active after SYNC_COUNT consecutive aligned COMs.
- After that, distributes data bytes round-robin across LANES parallel lanes, emitting one registered lane word per completed group; a partial group is flushed when a control symbol arrives.

Parameters:
- WIDTH, 8, symbol width in bits (serial bits per byte).
- LANES, 4, number of parallel output lanes (power of 2, >=2).
- COM, 8'hBC, alignment/comma symbol.
- IDL, 8'h7C, idle symbol.
- SYNC_COUNT, 4, consecutive aligned COMs needed to assert active (>=1).

Ports:
- clk  input  1  bit-rate clock; all state updates on rising edge.
- default_values  input  1  reset; asynchronous, active-low; clears all state.
- data_in  input  1  serial data, MSB first, sampled on rising edge.
- active  output  1  link locked and receiving.
- valid  output  1  one-cycle pulse per decoded data byte (non-COM, non-IDL) while active.
- data_out  output  LANES*WIDTH  lane k at bits [k*WIDTH +: WIDTH]; lane 0 is the first byte of the group.
- valid_out  output  LANES  per-lane valid mask for the current data_out.
- out_stb  output  1  one-cycle pulse when data_out/valid_out update.

Behaviour:
- Reset: with default_values low, all outputs are 0; state is SEARCH; shift register, bit counter, COM counter, lane pointer and lane buffer are 0. Release is synchronous to the next edge.
- Every edge: sr <= {sr[WIDTH-2:0], data_in}. The "incoming byte" at an edge is {sr[WIDTH-2:0], data_in}.
- FSM states: SEARCH, ALIGN, ACTIVE.
- SEARCH:
  - The incoming byte is compared every cycle (bit-slip).
  - On match with COM: go to ALIGN, bit counter = 0, COM counter = 1.
  - If SYNC_COUNT==1, go directly to ACTIVE instead.
- ALIGN:
  - Bit counter increments each cycle and wraps at WIDTH-1.
  - The incoming byte is evaluated only at the edge where counter == WIDTH-1.
  - If it is COM: COM counter +1; on reaching SYNC_COUNT, go to ACTIVE.
  - If it is anything else: return to SEARCH, COM counter = 0.
- ACTIVE:
  - active = 1, registered; it rises the cycle after the edge completing the SYNC_COUNT-th COM.
  - Bytes are evaluated every WIDTH cycles on the same boundary.
  - active stays high until reset; no loss-of-lock detection in this block.
- Data byte (not COM, not IDL) in ACTIVE:
  - valid pulses 1 cycle (registered, high the cycle after the byte-completing edge).
  - The byte is written to buffer[ptr], ptr advances.
  - If ptr was LANES-1: at that same edge data_out <= full buffer including the new byte, valid_out <= all ones, out_stb pulses, ptr <= 0.
- Control byte (COM or IDL) in ACTIVE:
  - If ptr != 0: flush. data_out gets the filled lanes; unfilled lanes are zero. valid_out <= mask of filled lanes (bits 0..ptr-1). out_stb pulses; ptr <= 0.
  - If ptr == 0: no output activity.
- Hold: data_out and valid_out hold their values between strobes. valid and out_stb are 0 outside their pulse cycles.
- Latency: byte-completing edge to valid/out_stb is 1 registered stage, so both are high during the following cycle.
- Mid-operation reset: immediate clear and return to SEARCH. A partial group is discarded, not flushed.
- Widths: lane pointer is clog2(LANES) bits. COM counter is clog2(SYNC_COUNT+1) bits and saturates.

Test Plan:
- Lock: after reset release, send COM x4 byte-aligned -> active rises 1 cycle after bit 32's edge; valid=0 and out_stb=0 throughout.
- False lock: COM x3 then 8'h00 -> active stays 0; FSM returns to SEARCH; a following COM x4 locks.
- Bit slip: 3 junk bits (101), then COM x4 -> locks with byte boundary aligned to the first COM; active=1.
- Full group: lock, then bytes 11,22,33,44 -> 4 valid pulses; a single out_stb; data_out=32'h44332211; valid_out=4'b1111.
- Partial flush: lock, then 55,66,IDL -> out_stb on the IDL boundary; data_out=32'h00006655; valid_out=4'b0011. A following IDL produces no out_stb.
- Reset mid-group: lock, 11,22, then assert default_values -> all outputs immediately 0; after release, active=0 until COM x4 is received again.
